// File: rtl/lpc_pkg.sv
// Shared types and defaults for the LPC encode stage sequencer and its memory-select mux.
package lpc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_RUN    = 3'd2,
        ST_DONE   = 3'd3,
        ST_ERR    = 3'd4
    } state_t;

    // Stage 2 (inverse filter) reads coefficients; earlier stages read autocorrelation.
    localparam logic [5:0] DEF_SEL_MAP  = {2'h1, 2'h0, 2'h0};
    localparam logic [1:0] DEF_IDLE_SEL = 2'h2;
    localparam logic [2:0] DEF_XSEL_MAP = 3'b100;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) r++;
        return r;
    endfunction

    // Index width that stays legal for a single-stage chain.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lpc_stage_watchdog.sv
// Per-stage watchdog: counts RUN cycles and flags expiry one cycle before the limit is reached.
module lpc_stage_watchdog #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] limit,
    output logic             expire
);

    logic [CNT_W-1:0] wdog;

    always_ff @(posedge clk) begin
        if (reset || clear)
            wdog <= '0;
        else if (enable)
            wdog <= wdog + CNT_W'(1);
    end

    // A zero limit disables the watchdog entirely.
    assign expire = enable && (limit != '0) && (wdog == limit - CNT_W'(1));

endmodule

// File: rtl/lpc_stage_sequencer.sv
// Top-level LPC pipeline sequencer: launches each stage in turn, waits for its ready,
// drives the shared-memory selects and handles continuous runs, abort and watchdog errors.
module lpc_stage_sequencer
    import lpc_pkg::*;
#(
    parameter int unsigned                  NUM_STAGES = 3,
    parameter int unsigned                  SEL_W      = 2,
    parameter logic [NUM_STAGES*SEL_W-1:0]  SEL_MAP    = DEF_SEL_MAP,
    parameter logic [SEL_W-1:0]             IDLE_SEL   = DEF_IDLE_SEL,
    parameter logic [NUM_STAGES-1:0]        XSEL_MAP   = DEF_XSEL_MAP,
    parameter int unsigned                  CNT_W      = 16,
    localparam int unsigned                 STG_W      = idx_w(NUM_STAGES)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  continuous,
    input  logic [CNT_W-1:0]      timeout_limit,
    input  logic [NUM_STAGES-1:0] stage_ready,
    output logic [NUM_STAGES-1:0] stage_reset,
    output logic [NUM_STAGES-1:0] stage_active,
    output logic [SEL_W-1:0]      a_rsel_sel,
    output logic                  x_raddr_sel,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [STG_W-1:0]      err_stage,
    output logic [CNT_W-1:0]      frame_count
);

    localparam logic [STG_W-1:0] LAST = STG_W'(NUM_STAGES - 1);

    state_t                  state, nxt_state;
    logic [STG_W-1:0]        stg, nxt_stg;
    logic [NUM_STAGES-1:0]   nxt_reset, nxt_active;
    logic [SEL_W-1:0]        nxt_sel;
    logic                    nxt_x, nxt_busy, nxt_done;
    logic                    frame_inc, err_set, launch_new, expire;

    function automatic logic [NUM_STAGES-1:0] onehot(input logic [STG_W-1:0] i);
        return NUM_STAGES'(1) << i;
    endfunction

    lpc_stage_watchdog #(.CNT_W(CNT_W)) u_wdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (state == ST_LAUNCH),
        .enable (state == ST_RUN),
        .limit  (timeout_limit),
        .expire (expire)
    );

    // Priority inside RUN: abort, then ready, then watchdog expiry.
    always_comb begin
        nxt_state = state;
        nxt_stg   = stg;
        nxt_reset = '0;
        nxt_done  = 1'b0;
        frame_inc = 1'b0;
        err_set   = 1'b0;
        case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    nxt_state = ST_LAUNCH;
                    nxt_stg   = '0;
                end else if (state == ST_DONE) begin
                    nxt_state = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                if (abort) begin
                    nxt_state = ST_IDLE;
                    nxt_reset = '1;
                end else begin
                    nxt_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    nxt_state = ST_IDLE;
                    nxt_reset = '1;
                end else if (stage_ready[stg]) begin
                    if (stg == LAST) begin
                        frame_inc = 1'b1;
                        nxt_done  = 1'b1;
                        if (continuous) begin
                            nxt_state = ST_LAUNCH;
                            nxt_stg   = '0;
                        end else begin
                            nxt_state = ST_DONE;
                        end
                    end else begin
                        nxt_state = ST_LAUNCH;
                        nxt_stg   = stg + STG_W'(1);
                    end
                end else if (expire) begin
                    nxt_state = ST_ERR;
                    nxt_reset = onehot(stg);
                    err_set   = 1'b1;
                end
            end
            default: nxt_state = ST_IDLE;
        endcase
        if (nxt_state == ST_LAUNCH)
            nxt_reset = onehot(nxt_stg);
    end

    assign launch_new = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERR);

    always_comb begin
        nxt_busy   = (nxt_state == ST_LAUNCH) || (nxt_state == ST_RUN);
        nxt_sel    = IDLE_SEL;
        nxt_x      = 1'b0;
        nxt_active = '0;
        if (nxt_busy) begin
            for (int unsigned k = 0; k < NUM_STAGES; k++) begin
                if (nxt_stg == STG_W'(k)) begin
                    nxt_sel       = SEL_MAP[k*SEL_W +: SEL_W];
                    nxt_x         = XSEL_MAP[k];
                    nxt_active[k] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            stg          <= '0;
            stage_reset  <= '0;
            stage_active <= '0;
            a_rsel_sel   <= IDLE_SEL;
            x_raddr_sel  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            err_stage    <= '0;
            frame_count  <= '0;
        end else begin
            state        <= nxt_state;
            stg          <= nxt_stg;
            stage_reset  <= nxt_reset;
            stage_active <= nxt_active;
            a_rsel_sel   <= nxt_sel;
            x_raddr_sel  <= nxt_x;
            busy         <= nxt_busy;
            done         <= nxt_done;
            if (frame_inc)
                frame_count <= frame_count + CNT_W'(1);
            if (err_set) begin
                error     <= 1'b1;
                err_stage <= stg;
            end else if (launch_new) begin
                error <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lpc_stage_sequencer.sv
// Directed bench for lpc_stage_sequencer with the default three-stage configuration.
module tb_lpc_stage_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        continuous = 1'b0;
    logic [15:0] timeout_limit = '0;
    logic [2:0]  stage_ready = '0;
    logic [2:0]  stage_reset, stage_active;
    logic [1:0]  a_rsel_sel;
    logic        x_raddr_sel, busy, done, error;
    logic [1:0]  err_stage;
    logic [15:0] frame_count;

    int unsigned total = 0, bad = 0;
    int unsigned cyc = 0, done_cnt = 0, last_done = 0, done_gap = 0, d0 = 0;

    lpc_stage_sequencer #(
        .NUM_STAGES (3),
        .SEL_W      (2),
        .CNT_W      (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .abort         (abort),
        .continuous    (continuous),
        .timeout_limit (timeout_limit),
        .stage_ready   (stage_ready),
        .stage_reset   (stage_reset),
        .stage_active  (stage_active),
        .a_rsel_sel    (a_rsel_sel),
        .x_raddr_sel   (x_raddr_sel),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .err_stage     (err_stage),
        .frame_count   (frame_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_gap  = cyc - last_done;
            last_done = cyc;
            done_cnt++;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered just after the edge that put stage idx into LAUNCH; completes it after k RUN cycles.
    task automatic run_stage(input int unsigned idx, input int unsigned k, input logic launch_rdy,
                             input logic [2:0] stray, input logic poke);
        logic [2:0] oh;
        logic [2:0] seen;
        oh = 3'b001 << idx;
        chk("launch_rst", stage_reset, oh);
        chk("launch_act", stage_active, oh);
        chk("launch_busy", busy, 1);
        chk("launch_asel", a_rsel_sel, (idx == 2) ? 2'h1 : 2'h0);
        chk("launch_xsel", x_raddr_sel, (idx == 2) ? 1 : 0);
        if (launch_rdy) stage_ready = oh;
        tick;
        stage_ready = stray;
        start = poke;
        seen = stage_reset;
        for (int unsigned j = 1; j < k; j++) begin
            tick;
            start = 1'b0;
            seen |= stage_reset;
        end
        chk("run_rst_quiet", seen, 0);
        chk("run_act", stage_active, oh);
        chk("run_busy", busy, 1);
        stage_ready = stray | oh;
        tick;
        stage_ready = '0;
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "bench did not finish");
    end

    initial begin
        // Test 1: reset values and one plain frame
        tick;
        tick;
        chk("rst_stage_reset", stage_reset, 0);
        chk("rst_active", stage_active, 0);
        chk("rst_asel", a_rsel_sel, 2'h2);
        chk("rst_xsel", x_raddr_sel, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_err_stage", err_stage, 0);
        chk("rst_frame_count", frame_count, 0);
        reset = 1'b0;
        tick;
        chk("idle_busy", busy, 0);
        start = 1'b1;
        tick;
        start = 1'b0;
        run_stage(0, 5, 1'b0, 3'b000, 1'b0);
        run_stage(1, 20, 1'b0, 3'b000, 1'b0);
        run_stage(2, 8, 1'b0, 3'b000, 1'b0);
        chk("t1_done", done, 1);
        chk("t1_frame_count", frame_count, 1);
        chk("t1_busy", busy, 0);
        chk("t1_active", stage_active, 0);
        chk("t1_asel", a_rsel_sel, 2'h2);
        chk("t1_xsel", x_raddr_sel, 0);
        tick;
        chk("t1_done_pulse", done, 0);
        chk("t1_done_cnt", done_cnt, 1);

        // Test 2: three continuous frames
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("t2_frame_reset", frame_count, 0);
        d0 = done_cnt;
        continuous = 1'b1;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int unsigned f = 0; f < 3; f++) begin
            run_stage(0, 3, 1'b0, 3'b000, 1'b0);
            run_stage(1, 3, 1'b0, 3'b000, 1'b0);
            if (f == 2) continuous = 1'b0;
            run_stage(2, 3, 1'b0, 3'b000, 1'b0);
            chk("t2_done", done, 1);
            chk("t2_frame_count", frame_count, f + 1);
        end
        chk("t2_final_busy", busy, 0);
        tick;
        chk("t2_done_cnt", done_cnt - d0, 3);
        chk("t2_done_gap", done_gap, 12);

        // Test 4: abort in idle does nothing; abort wins over ready of the last stage
        abort = 1'b1;
        tick;
        abort = 1'b0;
        chk("t4_idle_abort_rst", stage_reset, 0);
        chk("t4_idle_abort_busy", busy, 0);
        d0 = done_cnt;
        start = 1'b1;
        tick;
        start = 1'b0;
        run_stage(0, 2, 1'b0, 3'b000, 1'b0);
        run_stage(1, 2, 1'b0, 3'b000, 1'b0);
        chk("t4_launch2", stage_reset, 3'b100);
        tick;
        tick;
        stage_ready = 3'b100;
        abort = 1'b1;
        tick;
        stage_ready = '0;
        abort = 1'b0;
        chk("t4_abort_rst", stage_reset, 3'b111);
        chk("t4_abort_busy", busy, 0);
        chk("t4_abort_done", done, 0);
        chk("t4_abort_active", stage_active, 0);
        chk("t4_abort_fc", frame_count, 3);
        tick;
        chk("t4_abort_rst_clear", stage_reset, 0);
        chk("t4_no_done", done_cnt - d0, 0);

        // Test 5: stray readys, ready during LAUNCH, start while busy
        start = 1'b1;
        tick;
        start = 1'b0;
        run_stage(0, 6, 1'b0, 3'b100, 1'b1);
        run_stage(1, 4, 1'b1, 3'b000, 1'b0);
        run_stage(2, 3, 1'b0, 3'b001, 1'b0);
        chk("t5_done", done, 1);
        chk("t5_frame_count", frame_count, 4);
        chk("t5_busy", busy, 0);
        tick;

        // Test 3: watchdog on stage 1
        timeout_limit = 16'd10;
        start = 1'b1;
        tick;
        start = 1'b0;
        run_stage(0, 5, 1'b0, 3'b000, 1'b0);
        chk("t3_launch1", stage_reset, 3'b010);
        repeat (10) tick;
        chk("t3_pre_busy", busy, 1);
        chk("t3_pre_error", error, 0);
        tick;
        chk("t3_error", error, 1);
        chk("t3_err_stage", err_stage, 1);
        chk("t3_err_rst", stage_reset, 3'b010);
        chk("t3_err_busy", busy, 0);
        chk("t3_err_active", stage_active, 0);
        chk("t3_err_asel", a_rsel_sel, 2'h2);
        chk("t3_err_fc", frame_count, 4);
        tick;
        chk("t3_err_rst_clear", stage_reset, 0);
        chk("t3_error_sticky", error, 1);
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("t3_error_cleared", error, 0);
        chk("t3_relaunch", stage_reset, 3'b001);
        abort = 1'b1;
        tick;
        abort = 1'b0;
        chk("t3_abort_launch", stage_reset, 3'b111);
        chk("t3_abort_busy", busy, 0);
        timeout_limit = '0;

        // Test 6: reset in the middle of stage 1
        start = 1'b1;
        tick;
        start = 1'b0;
        run_stage(0, 2, 1'b0, 3'b000, 1'b0);
        tick;
        tick;
        chk("t6_mid_run", stage_active, 3'b010);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("t6_stage_reset", stage_reset, 0);
        chk("t6_active", stage_active, 0);
        chk("t6_asel", a_rsel_sel, 2'h2);
        chk("t6_xsel", x_raddr_sel, 0);
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_error", error, 0);
        chk("t6_err_stage", err_stage, 0);
        chk("t6_frame_count", frame_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
